// File: rtl/intc_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// register map, arbitration modes and STATUS field positions.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SOFTSET = 2'd3;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int STATUS_VALID_BIT = 31;
  localparam int STATUS_STATE_LSB = 16;
  localparam int STATUS_ID_LSB    = 0;

endpackage

// File: rtl/intc_arbiter.sv
// Combinational arbiter: picks the first requesting channel, scanning upward
// from 0 (fixed) or from rr_ptr with wrap-around (round-robin).
module intc_arbiter #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             mode,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  int start;
  int idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    start     = mode ? int'(rr_ptr) : 0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = start + k;
      if (idx >= N_IRQ) idx = idx - N_IRQ;
      if (!any_valid && req[idx[ID_W-1:0]]) begin
        grant     = idx[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intc_vec.sv
// Vectored interrupt controller: captures edge/level sources, arbitrates, and
// runs the request / ack / end-of-interrupt handshake with the MIPS core.
module intc_vec
  import intc_pkg::*;
#(
  parameter int               N_IRQ      = 4,
  parameter int               ARB_MODE   = ARB_FIXED,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = {N_IRQ{1'b1}},
  parameter logic [31:0]      VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0]      VEC_STRIDE = 32'd32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wd,
  output logic [31:0]      cfg_rd,
  output logic             cpu_irq,
  output logic [31:0]      cpu_vector,
  input  logic             cpu_ack,
  input  logic             cpu_eoi,
  output logic [31:0]      intc_test
);

  localparam int   ID_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic RR_MODE = (ARB_MODE == ARB_RR);

  logic [N_IRQ-1:0] enable, pending, prev_irq;
  logic [N_IRQ-1:0] set_vec, clr_vec, pending_nxt;
  state_t           state;
  logic [ID_W-1:0]  active_id, rr_ptr, next_ptr, grant;
  logic             active_valid, any_valid;
  logic [7:0]       id8;
  logic [31:0]      status_word;
  logic             unused_wd;

  assign unused_wd = ^cfg_wd[31:N_IRQ];

  intc_arbiter #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_arb (
    .req       (pending & enable),
    .rr_ptr    (rr_ptr),
    .mode      (RR_MODE),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Sets are OR-ed in after clears so a same-cycle set always wins.
  always_comb begin
    set_vec = (irq_in & ~prev_irq & EDGE_MASK) | (irq_in & ~EDGE_MASK);
    if (cfg_we && cfg_addr == ADDR_SOFTSET) set_vec = set_vec | cfg_wd[N_IRQ-1:0];
    clr_vec = '0;
    if (cfg_we && cfg_addr == ADDR_PENDING) clr_vec = cfg_wd[N_IRQ-1:0];
    if (state == ST_REQ && cpu_ack) clr_vec[active_id] = 1'b1;
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enable   <= '0;
      pending  <= '0;
      prev_irq <= '0;
    end else begin
      prev_irq <= irq_in;
      pending  <= pending_nxt;
      if (cfg_we && cfg_addr == ADDR_ENABLE) enable <= cfg_wd[N_IRQ-1:0];
    end
  end

  assign next_ptr = (active_id == ID_W'(N_IRQ - 1)) ? '0 : active_id + 1'b1;

  // Unused encoding 3 falls into the default arm and behaves as IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      cpu_irq      <= 1'b0;
      cpu_vector   <= VEC_BASE;
      active_id    <= '0;
      active_valid <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (cpu_ack) begin
            state        <= ST_SERVICE;
            active_valid <= 1'b1;
            cpu_irq      <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (cpu_eoi) begin
            state        <= ST_IDLE;
            active_valid <= 1'b0;
            if (RR_MODE) rr_ptr <= next_ptr;
          end
        end
        default: begin
          if (any_valid) begin
            active_id  <= grant;
            cpu_vector <= VEC_BASE + VEC_STRIDE * 32'(grant);
            state      <= ST_REQ;
            cpu_irq    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign id8 = 8'(active_id);

  always_comb begin
    status_word                             = '0;
    status_word[STATUS_VALID_BIT]           = active_valid;
    status_word[STATUS_STATE_LSB +: 2]      = state;
    status_word[STATUS_ID_LSB +: 8]         = id8;
  end

  always_comb begin
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rd = 32'(enable);
      ADDR_PENDING: cfg_rd = 32'(pending);
      ADDR_STATUS:  cfg_rd = status_word;
      default:      cfg_rd = '0;
    endcase
  end

  assign intc_test = {id8, 6'b0, state, 16'(pending)};

endmodule

// File: tb/tb_intc_vec.sv
// Bench for intc_vec: a fixed-priority/edge instance and a round-robin/level-ch0
// instance share stimulus; directed table, corner sequences, then random vs model.
module tb_intc_vec;

  logic        sys_clk, sys_rst_n;
  logic [3:0]  irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wd;
  logic        cpu_ack, cpu_eoi;
  logic        o_irq [2];
  logic [31:0] o_vec [2];
  logic [31:0] o_rd  [2];
  logic [31:0] o_dbg [2];

  int n_checks, n_err;

  intc_vec #(.N_IRQ(4), .ARB_MODE(0)) u_fix (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .irq_in(irq_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wd(cfg_wd), .cfg_rd(o_rd[0]),
    .cpu_irq(o_irq[0]), .cpu_vector(o_vec[0]), .cpu_ack(cpu_ack),
    .cpu_eoi(cpu_eoi), .intc_test(o_dbg[0])
  );

  intc_vec #(.N_IRQ(4), .ARB_MODE(1), .EDGE_MASK(4'b1110)) u_rr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .irq_in(irq_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wd(cfg_wd), .cfg_rd(o_rd[1]),
    .cpu_irq(o_irq[1]), .cpu_vector(o_vec[1]), .cpu_ack(cpu_ack),
    .cpu_eoi(cpu_eoi), .intc_test(o_dbg[1])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        ack;
    logic        eoi;
    logic        e_irq;
    logic [31:0] e_vec;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] irq, logic we, logic [1:0] addr, logic [31:0] wd,
                              logic ack, logic eoi, logic e_irq, logic [31:0] e_vec,
                              logic [31:0] e_rd);
    vec_t v;
    v.irq = irq; v.we = we; v.addr = addr; v.wd = wd; v.ack = ack; v.eoi = eoi;
    v.e_irq = e_irq; v.e_vec = e_vec; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wd = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    idle_inputs();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_irq(input int which, input string nm);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge sys_clk); #1;
      if (o_irq[which]) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: cpu_irq stayed 0, expected 1 within 6 clocks", nm);
    end
  endtask

  // Behavioural reference: instance 0 = fixed/all-edge, instance 1 = round-robin/ch0 level.
  bit [3:0]    m_en [2], m_pend [2], m_prev [2];
  int          m_st [2], m_id [2], m_rr [2];
  bit          m_av [2];
  logic [31:0] m_vec [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_en[m] = 0; m_pend[m] = 0; m_prev[m] = 0;
      m_st[m] = 0; m_id[m] = 0; m_rr[m] = 0; m_av[m] = 0; m_vec[m] = 32'h0;
    end
  endtask

  task automatic model_step(input int m);
    bit [3:0] set_b, clr_b, edge_m;
    int w, start, j;
    edge_m = (m == 1) ? 4'b1110 : 4'b1111;
    set_b = 0; clr_b = 0;
    for (int i = 0; i < 4; i++) begin
      if (edge_m[i]) begin
        if (irq_in[i] && !m_prev[m][i]) set_b[i] = 1'b1;
      end else if (irq_in[i]) set_b[i] = 1'b1;
    end
    if (cfg_we && cfg_addr == 2'd3) set_b = set_b | cfg_wd[3:0];
    if (cfg_we && cfg_addr == 2'd1) clr_b = cfg_wd[3:0];
    if (m_st[m] == 1 && cpu_ack) clr_b[m_id[m]] = 1'b1;
    w = -1;
    start = (m == 1) ? m_rr[m] : 0;
    for (int k = 0; k < 4; k++) begin
      j = (start + k) % 4;
      if (w < 0 && m_pend[m][j] && m_en[m][j]) w = j;
    end
    case (m_st[m])
      0: if (w >= 0) begin m_id[m] = w; m_vec[m] = w * 32; m_st[m] = 1; end
      1: if (cpu_ack) begin m_st[m] = 2; m_av[m] = 1'b1; end
      default: if (cpu_eoi) begin
        m_st[m] = 0; m_av[m] = 1'b0;
        if (m == 1) m_rr[m] = (m_id[m] + 1) % 4;
      end
    endcase
    if (cfg_we && cfg_addr == 2'd0) m_en[m] = cfg_wd[3:0];
    m_prev[m] = irq_in;
    m_pend[m] = (m_pend[m] & ~clr_b) | set_b;
  endtask

  function automatic logic [31:0] m_rd(int m, logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_en[m]};
      2'd1:    return {28'b0, m_pend[m]};
      2'd2:    return {m_av[m], 13'b0, 2'(m_st[m]), 8'b0, 8'(m_id[m])};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    n_checks = 0; n_err = 0;
    idle_inputs();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;

    // Reset while a request is outstanding
    @(negedge sys_clk) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wd = 32'hF; end
    @(negedge sys_clk) begin cfg_we = 1'b0; irq_in = 4'b0001; end
    @(negedge sys_clk) irq_in = 4'b0000;
    @(posedge sys_clk); #1;
    chk("rst_pre_irq_fix", 32'(o_irq[0]), 32'd1);
    chk("rst_pre_irq_rr", 32'(o_irq[1]), 32'd1);
    chk("rst_pre_vec", o_vec[0], 32'h0);
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b0; cfg_addr = 2'd1;
    #1;
    chk("rst_irq_fix", 32'(o_irq[0]), 32'd0);
    chk("rst_irq_rr", 32'(o_irq[1]), 32'd0);
    chk("rst_pending", o_rd[0], 32'h0);
    chk("rst_dbg_fix", o_dbg[0], 32'h0);
    chk("rst_dbg_rr", o_dbg[1], 32'h0);
    cfg_addr = 2'd0;
    #1;
    chk("rst_enable", o_rd[0], 32'h0);
    chk("rst_vec", o_vec[0], 32'h0);
    #1 sys_rst_n = 1'b1;

    // Directed table on the fixed-priority instance
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'hF,         0, 0, 0, 32'h0,  32'hF));
    tbl.push_back(mk(4'hA, 0, 2'd1, 32'h0,         0, 0, 0, 32'h0,  32'hA));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         1, 0, 1, 32'h20, 32'hA));
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'h0,         0, 0, 1, 32'h20, 32'h0));
    tbl.push_back(mk(4'h0, 0, 2'd2, 32'h0,         1, 0, 0, 32'h0,  32'h8002_0001));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         0, 0, 0, 32'h0,  32'h8));
    tbl.push_back(mk(4'h0, 1, 2'd0, 32'hFFFF_FFFF, 0, 1, 0, 32'h0,  32'hF));
    tbl.push_back(mk(4'h0, 0, 2'd2, 32'h0,         0, 0, 1, 32'h60, 32'h0001_0003));
    tbl.push_back(mk(4'h0, 0, 2'd2, 32'h0,         1, 1, 0, 32'h0,  32'h8002_0003));
    tbl.push_back(mk(4'h0, 0, 2'd2, 32'h0,         0, 1, 0, 32'h0,  32'h0000_0003));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         1, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(4'h4, 1, 2'd1, 32'h4,         0, 0, 0, 32'h0,  32'h4));
    tbl.push_back(mk(4'h4, 1, 2'd1, 32'h4,         0, 0, 1, 32'h40, 32'h0));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         1, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(4'h0, 0, 2'd2, 32'h0,         0, 1, 0, 32'h0,  32'h0000_0002));
    tbl.push_back(mk(4'h0, 1, 2'd2, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,  32'h0000_0002));
    tbl.push_back(mk(4'h0, 1, 2'd3, 32'h1,         0, 0, 0, 32'h0,  32'h0));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         0, 0, 1, 32'h0,  32'h1));
    tbl.push_back(mk(4'h0, 0, 2'd0, 32'h0,         1, 0, 0, 32'h0,  32'hF));
    tbl.push_back(mk(4'h0, 0, 2'd1, 32'h0,         0, 1, 0, 32'h0,  32'h0));
    foreach (tbl[r]) begin
      @(negedge sys_clk);
      irq_in = tbl[r].irq; cfg_we = tbl[r].we; cfg_addr = tbl[r].addr; cfg_wd = tbl[r].wd;
      cpu_ack = tbl[r].ack; cpu_eoi = tbl[r].eoi;
      @(posedge sys_clk); #1;
      chk($sformatf("tbl%0d_irq", r), 32'(o_irq[0]), 32'(tbl[r].e_irq));
      if (tbl[r].e_irq) chk($sformatf("tbl%0d_vec", r), o_vec[0], tbl[r].e_vec);
      chk($sformatf("tbl%0d_rd", r), o_rd[0], tbl[r].e_rd);
    end

    // Round-robin with SOFTSET held: grants 0,1,2,3,0 (fixed instance always 0)
    do_reset();
    @(negedge sys_clk) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wd = 32'hF; end
    @(negedge sys_clk) cfg_addr = 2'd3;
    for (int n = 0; n < 5; n++) begin
      wait_irq(1, $sformatf("rr%0d_req", n));
      chk($sformatf("rr%0d_vec", n), o_vec[1], 32'((n % 4) * 32));
      chk($sformatf("rr%0d_fix_vec", n), o_vec[0], 32'h0);
      chk($sformatf("rr%0d_fix_irq", n), 32'(o_irq[0]), 32'd1);
      @(negedge sys_clk) cpu_ack = 1'b1;
      @(negedge sys_clk) begin cpu_ack = 1'b0; cpu_eoi = 1'b1; end
      @(negedge sys_clk) cpu_eoi = 1'b0;
    end

    // Level channel 0 held high across the ack
    do_reset();
    @(negedge sys_clk) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wd = 32'hF; end
    @(negedge sys_clk) begin cfg_we = 1'b0; irq_in = 4'b0001; end
    wait_irq(1, "lvl_req1");
    chk("lvl_vec1", o_vec[1], 32'h0);
    @(negedge sys_clk) begin cpu_ack = 1'b1; cfg_addr = 2'd1; end
    @(posedge sys_clk); #1;
    chk("lvl_pend_after_ack", o_rd[1], 32'h1);
    chk("edge_pend_after_ack", o_rd[0], 32'h0);
    @(negedge sys_clk) begin cpu_ack = 1'b0; cpu_eoi = 1'b1; end
    @(negedge sys_clk) cpu_eoi = 1'b0;
    wait_irq(1, "lvl_req2");
    chk("lvl_vec2", o_vec[1], 32'h0);
    chk("edge_no_req2", 32'(o_irq[0]), 32'd0);

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      irq_in   = 4'($urandom_range(0, 15));
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wd   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      cpu_ack  = ($urandom_range(0, 2) == 0);
      cpu_eoi  = ($urandom_range(0, 2) == 0);
      model_step(0);
      model_step(1);
      @(posedge sys_clk); #1;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rnd%0d_irq[%0d]", c, m), 32'(o_irq[m]), 32'(m_st[m] == 1));
        if (m_st[m] == 1) chk($sformatf("rnd%0d_vec[%0d]", c, m), o_vec[m], m_vec[m]);
        chk($sformatf("rnd%0d_rd[%0d]", c, m), o_rd[m], m_rd(m, cfg_addr));
        chk($sformatf("rnd%0d_dbg[%0d]", c, m), o_dbg[m],
            {8'(m_id[m]), 6'b0, 2'(m_st[m]), 12'b0, m_pend[m]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
